// File: rtl/contador_arbitro.sv
// Round-robin arbiter and run sequencer for one shared up/down counter serving two requesters.
// Optional abort-on-request-drop during a run is enabled by defining CONTADOR_ABORT_EN.
module contador_arbitro #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [1:0]       Req,
    input  logic [1:0]       Dir,
    input  logic [WIDTH-1:0] Alvo0,
    input  logic [WIDTH-1:0] Alvo1,
    output logic [1:0]       Grant,
    output logic             Busy,
    output logic [WIDTH-1:0] Contagem,
    output logic [1:0]       Fim,
    output logic             f
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [1:0]       grant_q,  grant_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [1:0]       fim_q,    fim_d;
    logic             ultimo_q, ultimo_d;
    logic             win_q,    win_d;
    logic             dir_q,    dir_d;
    logic [WIDTH-1:0] alvo_q,   alvo_d;

    logic             arb_win;
    logic [WIDTH-1:0] arb_alvo;
    logic [WIDTH-1:0] terminal;
    logic             at_term;
    logic             abort;

    // Tie goes to the requester that did not own the previous run.
    always_comb begin
        arb_win  = (Req == 2'b11) ? ~ultimo_q : Req[1];
        arb_alvo = arb_win ? Alvo1 : Alvo0;
        terminal = dir_q ? alvo_q : '0;
        at_term  = (cnt_q == terminal);
    end

`ifdef CONTADOR_ABORT_EN
    always_comb abort = ~Req[win_q];
`else
    always_comb abort = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            cnt_q    <= '0;
            fim_q    <= 2'b00;
            ultimo_q <= 1'b1;
            win_q    <= 1'b0;
            dir_q    <= 1'b0;
            alvo_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            fim_q    <= fim_d;
            ultimo_q <= ultimo_d;
            win_q    <= win_d;
            dir_q    <= dir_d;
            alvo_q   <= alvo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        fim_d    = fim_q;
        ultimo_d = ultimo_q;
        win_d    = win_q;
        dir_d    = dir_q;
        alvo_d   = alvo_q;

        case (state_q)
            IDLE: begin
                if (Req != 2'b00) begin
                    win_d   = arb_win;
                    grant_d = arb_win ? 2'b10 : 2'b01;
                    dir_d   = Dir[arb_win];
                    alvo_d  = arb_alvo;
                    cnt_d   = Dir[arb_win] ? '0 : arb_alvo;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The step is skipped at the terminal value, so the counter never wraps.
                if (abort) begin
                    state_d = DONE;
                end else if (at_term) begin
                    state_d = DONE;
                    fim_d   = win_q ? 2'b10 : 2'b01;
                end else if (dir_q) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            DONE: begin
                fim_d    = 2'b00;
                grant_d  = 2'b00;
                ultimo_d = win_q;
                state_d  = IDLE;
            end
            default: begin
                fim_d   = 2'b00;
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Grant    = grant_q;
        Contagem = cnt_q;
        Fim      = fim_q;
        Busy     = (state_q != IDLE);
        f        = (state_q == RUN) && at_term;
    end

endmodule

// File: tb/tb_contador_arbitro.sv
// Directed bench for contador_arbitro: per-cycle vector table plus hand sequences for async reset and abort.
module tb_contador_arbitro;

    logic       Clock;
    logic       Reset_n;
    logic [1:0] Req;
    logic [1:0] Dir;
    logic [2:0] Alvo0;
    logic [2:0] Alvo1;
    logic [1:0] Grant;
    logic       Busy;
    logic [2:0] Contagem;
    logic [1:0] Fim;
    logic       f_o;

    int n_chk  = 0;
    int n_fail = 0;

    contador_arbitro #(.WIDTH(3)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .Dir      (Dir),
        .Alvo0    (Alvo0),
        .Alvo1    (Alvo1),
        .Grant    (Grant),
        .Busy     (Busy),
        .Contagem (Contagem),
        .Fim      (Fim),
        .f        (f_o)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] dir;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [1:0] eg;
        logic       eb;
        logic [2:0] ec;
        logic [1:0] ef;
        logic       eff;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int row, input logic [1:0] eg, input logic eb,
                           input logic [2:0] ec, input logic [1:0] ef, input logic eff);
        chk({tag, ".grant"}, row, 32'(Grant), 32'(eg));
        chk({tag, ".busy"},  row, 32'(Busy), 32'(eb));
        chk({tag, ".cnt"},   row, 32'(Contagem), 32'(ec));
        chk({tag, ".fim"},   row, 32'(Fim), 32'(ef));
        chk({tag, ".f"},     row, 32'(f_o), 32'(eff));
    endtask

    task automatic add(input logic r, input logic [1:0] q, input logic [1:0] d, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [1:0] eg, input logic eb, input logic [2:0] ec,
                       input logic [1:0] ef, input logic eff);
        vec_t v;
        v.rst_n = r; v.req = q; v.dir = d; v.a0 = a0; v.a1 = a1;
        v.eg = eg; v.eb = eb; v.ec = ec; v.ef = ef; v.eff = eff;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] q, input logic [1:0] d,
                         input logic [2:0] a0, input logic [2:0] a1);
        @(negedge Clock);
        Reset_n = r; Req = q; Dir = d; Alvo0 = a0; Alvo1 = a1;
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0; Req = 2'b00; Dir = 2'b00; Alvo0 = '0; Alvo1 = '0;

        // rst req dir a0 a1 | grant busy cnt fim f   (outputs after the edge)
        add(0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 0, 3'd0, 2'b00, 0);
        // up run to 3 for requester 0
        add(1, 2'b01, 2'b01, 3'd3, 3'd0, 2'b01, 1, 3'd0, 2'b00, 0);
        add(1, 2'b01, 2'b01, 3'd3, 3'd0, 2'b01, 1, 3'd1, 2'b00, 0);
        add(1, 2'b01, 2'b01, 3'd3, 3'd0, 2'b01, 1, 3'd2, 2'b00, 0);
        add(1, 2'b01, 2'b01, 3'd3, 3'd0, 2'b01, 1, 3'd3, 2'b00, 1);
        add(1, 2'b01, 2'b01, 3'd3, 3'd0, 2'b01, 1, 3'd3, 2'b01, 0);
        add(1, 2'b00, 2'b01, 3'd3, 3'd0, 2'b00, 0, 3'd3, 2'b00, 0);
        // round robin with both requesting, down runs
        add(0, 2'b11, 2'b00, 3'd2, 3'd1, 2'b00, 0, 3'd0, 2'b00, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b01, 1, 3'd2, 2'b00, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b01, 1, 3'd1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b01, 1, 3'd0, 2'b00, 1);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b01, 1, 3'd0, 2'b01, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b00, 0, 3'd0, 2'b00, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b10, 1, 3'd1, 2'b00, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b10, 1, 3'd0, 2'b00, 1);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b10, 1, 3'd0, 2'b10, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b00, 0, 3'd0, 2'b00, 0);
        add(1, 2'b11, 2'b00, 3'd2, 3'd1, 2'b01, 1, 3'd2, 2'b00, 0);
        // Alvo=0 down run for requester 1
        add(0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 0, 3'd0, 2'b00, 0);
        add(1, 2'b10, 2'b00, 3'd0, 3'd0, 2'b10, 1, 3'd0, 2'b00, 1);
        add(1, 2'b10, 2'b00, 3'd0, 3'd0, 2'b10, 1, 3'd0, 2'b10, 0);
        add(1, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 0, 3'd0, 2'b00, 0);
        // full-range up run; Alvo0/Dir change mid-run must be ignored
        add(1, 2'b01, 2'b01, 3'd7, 3'd0, 2'b01, 1, 3'd0, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd1, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd2, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd3, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd4, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd5, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd6, 2'b00, 0);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd7, 2'b00, 1);
        add(1, 2'b01, 2'b00, 3'd2, 3'd5, 2'b01, 1, 3'd7, 2'b01, 0);
        add(1, 2'b00, 2'b00, 3'd2, 3'd5, 2'b00, 0, 3'd7, 2'b00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].dir, vecs[i].a0, vecs[i].a1);
            tick();
            chk_all("vec", i, vecs[i].eg, vecs[i].eb, vecs[i].ec, vecs[i].ef, vecs[i].eff);
        end

        // Asynchronous reset in the middle of an up run
        drive(0, 2'b00, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1, 2'b01, 2'b01, 3'd5, 3'd0);
        tick();
        tick();
        tick();
        chk_all("areset.pre", 0, 2'b01, 1, 3'd2, 2'b00, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all("areset.mid", 0, 2'b00, 0, 3'd0, 2'b00, 0);
        drive(1, 2'b11, 2'b00, 3'd2, 3'd1);
        tick();
        chk_all("areset.post", 0, 2'b01, 1, 3'd2, 2'b00, 0);

        // Request dropped mid-run
        drive(0, 2'b00, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1, 2'b01, 2'b01, 3'd6, 3'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all("drop.run", k, 2'b01, 1, 3'(k), 2'b00, 0);
        end
        drive(1, 2'b00, 2'b01, 3'd6, 3'd0);
`ifdef CONTADOR_ABORT_EN
        tick();
        chk_all("abort.done", 0, 2'b01, 1, 3'd3, 2'b00, 0);
        tick();
        chk_all("abort.idle", 0, 2'b00, 0, 3'd3, 2'b00, 0);
`else
        for (int k = 4; k < 7; k++) begin
            tick();
            chk_all("drop.run", k, 2'b01, 1, 3'(k), 2'b00, (k == 6) ? 1'b1 : 1'b0);
        end
        tick();
        chk_all("drop.done", 0, 2'b01, 1, 3'd6, 2'b01, 0);
        tick();
        chk_all("drop.idle", 0, 2'b00, 0, 3'd6, 2'b00, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
